// File: rtl/cpu_0_mul_seq.sv
// -----------------------------------------------------------------------------
// cpu_0_mul_seq
//
// Multiply sequencer in front of the CPU's 32x32 multiply cell. The cell only
// returns the low 32 bits of its product, one clock after its operands are
// presented. A request is split into four zero-extended 16x16 passes whose
// products are summed into a 64-bit accumulator. The low word (MUL) or the
// high word (MULXUU / MULXSU / MULXSS) of the full product is returned.
//
// Signed ops multiply magnitudes; the sign is applied once, at the end, as a
// 64-bit two's complement negate.
//
// Optional feature (compile-time macro CPU_0_MUL_FAST_LO_EN):
//   defined     - MUL (op 00) drives the full 32-bit operands straight to the
//                 cell and returns the cell's low word; latency 2.
//   undefined   - every op, MUL included, takes the 4-pass path; latency 6.
//
// Ports:
//   clk               in   1   clock, all state changes on rising edge
//   reset             in   1   synchronous, active-high
//   req_valid         in   1   request present
//   req_ready         out  1   sequencer can accept (IDLE only)
//   req_op            in   2   00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   req_src1          in   32  operand A (signed for MULXSU / MULXSS)
//   req_src2          in   32  operand B (signed for MULXSS)
//   rsp_valid         out  1   one-cycle result pulse
//   rsp_result        out  32  result, held until the next rsp_valid
//   A_mul_src1        out  32  operand to multiply cell (0 when not issuing)
//   A_mul_src2        out  32  operand to multiply cell (0 when not issuing)
//   A_mul_cell_result in   32  cell result, one cycle after operands
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds req_op/req_src* stable until
// then, and req_valid while busy is ignored. rsp_valid is a single-cycle
// pulse with no backpressure; rsp_result keeps its value afterwards.
//
// The FSM state is held in the named enum signal 'state'.
// -----------------------------------------------------------------------------
module cpu_0_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // The fast states are only entered when CPU_0_MUL_FAST_LO_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_SIGN       = 3'd3,
    ST_FAST_ISSUE = 3'd4,
    ST_FAST_CAP   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  pass_q, pass_nxt;

  logic [1:0]  op_q;
  logic [31:0] a_q;      // magnitude of A (raw for unsigned use)
  logic [31:0] b_q;      // magnitude of B (raw for unsigned use)
  logic        neg_q;    // final product must be negated
  logic [63:0] acc_q;
  logic [63:0] result;

  logic [15:0] a_half;
  logic [15:0] b_half;

  // |x| as an unsigned 32-bit value; |0x80000000| stays 0x80000000.
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Place a 16x16 partial product at the weight of the pass that made it.
  function automatic logic [63:0] weigh(input logic [1:0] k, input logic [31:0] p);
    logic [63:0] w;
    case (k)
      2'd0:    w = {32'd0, p};
      2'd3:    w = {p, 32'd0};
      default: w = {16'd0, p, 16'd0};
    endcase
    return w;
  endfunction

  // Pass order: 0 lo*lo, 1 lo*hi, 2 hi*lo, 3 hi*hi.
  assign a_half = pass_q[1] ? a_q[31:16] : a_q[15:0];
  assign b_half = pass_q[0] ? b_q[31:16] : b_q[15:0];

  assign result = neg_q ? (64'd0 - acc_q) : acc_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pass_q <= 2'd0;
    end else begin
      state  <= state_nxt;
      pass_q <= pass_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and cell operand drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pass_nxt   = pass_q;
    req_ready  = 1'b0;
    A_mul_src1 = 32'd0;
    A_mul_src2 = 32'd0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pass_nxt = 2'd0;
`ifdef CPU_0_MUL_FAST_LO_EN
          state_nxt = (req_op == OP_MUL) ? ST_FAST_ISSUE : ST_ISSUE;
`else
          state_nxt = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        A_mul_src1 = {16'd0, a_half};
        A_mul_src2 = {16'd0, b_half};
        if (pass_q == 2'd3) begin
          state_nxt = ST_DRAIN;
        end else begin
          pass_nxt = pass_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_SIGN;
      end
      ST_SIGN: begin
        state_nxt = ST_IDLE;
      end
      ST_FAST_ISSUE: begin
        A_mul_src1 = a_q;
        A_mul_src2 = b_q;
        state_nxt  = ST_FAST_CAP;
      end
      ST_FAST_CAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand latch, accumulation, result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 2'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      neg_q      <= 1'b0;
      acc_q      <= 64'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= (req_op == OP_MULXSU || req_op == OP_MULXSS) ? mag(req_src1) : req_src1;
            b_q   <= (req_op == OP_MULXSS) ? mag(req_src2) : req_src2;
            neg_q <= (req_op == OP_MULXSS) ? (req_src1[31] ^ req_src2[31]) :
                     (req_op == OP_MULXSU) ? req_src1[31] : 1'b0;
            acc_q <= 64'd0;
          end
        end
        ST_ISSUE: begin
          // The cell answers one cycle late: while pass k is driven, the
          // result on the cell port belongs to pass k-1.
          if (pass_q != 2'd0) begin
            acc_q <= acc_q + weigh(pass_q - 2'd1, A_mul_cell_result);
          end
        end
        ST_DRAIN: begin
          acc_q <= acc_q + weigh(2'd3, A_mul_cell_result);
        end
        ST_SIGN: begin
          rsp_valid  <= 1'b1;
          rsp_result <= (op_q == OP_MUL) ? result[31:0] : result[63:32];
        end
        ST_FAST_CAP: begin
          rsp_valid  <= 1'b1;
          rsp_result <= A_mul_cell_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
